// File: rtl/box_filter_pkg.sv
// Shared types and helpers for the streaming WIN x WIN box filter.
package box_filter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int MAX_WIN   = 7;
  localparam int MAX_TAPS  = MAX_WIN * MAX_WIN;
  localparam int MAX_CNT_W = $clog2(MAX_TAPS + 1);

  function automatic int half_win(input int win);
    return win / 2;
  endfunction

  // Accepted pixels between a pixel entering and it reaching the window centre.
  function automatic int pipe_delay(input int img_w, input int win);
    return (win / 2) * img_w + (win / 2);
  endfunction

  function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_TAPS-1:0] v,
                                                    input int win);
    logic [MAX_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_TAPS; i++) begin
      if (i < win * win) cnt = cnt + MAX_CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/box_filter_linebuf.sv
// WIN-1 full-line delays feeding a WIN x WIN window; taps[k*WIN+j] is the pixel
// k lines and j columns older than the newest pixel.
module box_filter_linebuf
  import box_filter_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int WIN   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift,
  input  logic               pix,
  output logic [WIN*WIN-1:0] taps
);

  logic [WIN-1:0]   row_in;
  logic [IMG_W-1:0] lb_reg  [WIN-1];
  logic [WIN-1:0]   win_reg [WIN];

  assign row_in[0] = pix;

  for (genvar gi = 0; gi < WIN - 1; gi++) begin : g_lb
    always_ff @(posedge clk) begin
      if (rst) begin
        lb_reg[gi] <= '0;
      end else if (shift) begin
        lb_reg[gi] <= {lb_reg[gi][IMG_W-2:0], row_in[gi]};
      end
    end
    assign row_in[gi+1] = lb_reg[gi][IMG_W-1];
  end

  for (genvar gi = 0; gi < WIN; gi++) begin : g_win
    always_ff @(posedge clk) begin
      if (rst) begin
        win_reg[gi] <= '0;
      end else if (shift) begin
        win_reg[gi] <= {win_reg[gi][WIN-2:0], row_in[gi]};
      end
    end
    assign taps[gi*WIN +: WIN] = win_reg[gi];
  end

endmodule

// File: rtl/box_filter_stream.sv
// Streaming WIN x WIN popcount threshold filter over a raster 1-bit motion map,
// with zero padding at the borders and a centre-pixel bypass.
module box_filter_stream
  import box_filter_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int WIN   = 3,
  localparam int CNT_W = $clog2(WIN * WIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] threshold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic             in_pix,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_pix
);

  localparam int H      = half_win(WIN);
  localparam int D      = pipe_delay(IMG_W, WIN);
  localparam int N      = IMG_W * IMG_H;
  localparam int ICNT_W = $clog2(N + D + 1);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int COL_W  = $clog2(IMG_W);

  state_t              state_reg, state_next;
  logic [ICNT_W-1:0]   in_cnt_reg, in_cnt_next;
  logic [ROW_W-1:0]    o_row_reg, o_row_next;
  logic [COL_W-1:0]    o_col_reg, o_col_next;
  logic                enable_q_reg;
  logic [CNT_W-1:0]    threshold_q_reg;
  logic                gen_reg;
  logic [ROW_W-1:0]    cen_row_reg;
  logic [COL_W-1:0]    cen_col_reg;
  logic                out_valid_reg, out_sof_reg, out_eol_reg, out_pix_reg;

  logic                accept, sof_acc, shift, produce, lb_pix;
  logic [WIN*WIN-1:0]  taps, masked_taps;
  logic [WIN-1:0]      row_ok, col_ok;
  logic [CNT_W-1:0]    win_cnt;
  logic                filt_pix;

  assign in_ready = (state_reg != FLUSH);
  assign accept   = in_valid & in_ready;
  assign sof_acc  = accept & in_sof;

  always_comb begin
    state_next  = state_reg;
    in_cnt_next = in_cnt_reg;
    shift       = 1'b0;
    produce     = 1'b0;
    lb_pix      = in_pix;
    case (state_reg)
      IDLE: begin
        if (sof_acc) begin
          state_next  = FILL;
          in_cnt_next = ICNT_W'(1);
          shift       = 1'b1;
        end
      end
      FILL, RUN: begin
        if (sof_acc) begin
          // A new frame restarts the fill; stale buffer data is hidden by masking.
          state_next  = FILL;
          in_cnt_next = ICNT_W'(1);
          shift       = 1'b1;
        end else if (accept) begin
          shift       = 1'b1;
          in_cnt_next = in_cnt_reg + ICNT_W'(1);
          if (state_reg == FILL) begin
            if (in_cnt_reg == ICNT_W'(D - 1)) state_next = RUN;
          end else begin
            produce = 1'b1;
            if (in_cnt_reg == ICNT_W'(N - 1)) state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        shift       = 1'b1;
        produce     = 1'b1;
        lb_pix      = 1'b0;
        in_cnt_next = in_cnt_reg + ICNT_W'(1);
        if (in_cnt_reg == ICNT_W'(N + D - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_row_next = o_row_reg;
    o_col_next = o_col_reg;
    if (sof_acc) begin
      o_row_next = '0;
      o_col_next = '0;
    end else if (produce) begin
      if (o_col_reg == COL_W'(IMG_W - 1)) begin
        o_col_next = '0;
        o_row_next = o_row_reg + ROW_W'(1);
      end else begin
        o_col_next = o_col_reg + COL_W'(1);
      end
    end
  end

  box_filter_linebuf #(
    .IMG_W (IMG_W),
    .WIN   (WIN)
  ) u_linebuf (
    .clk   (clk),
    .rst   (rst),
    .shift (shift),
    .pix   (lb_pix),
    .taps  (taps)
  );

  // Window row k / column j sits H-k rows and H-j columns away from the centre.
  for (genvar gi = 0; gi < WIN; gi++) begin : g_mask
    localparam int OFS = H - gi;
    assign row_ok[gi] = (int'(cen_row_reg) + OFS >= 0) && (int'(cen_row_reg) + OFS < IMG_H);
    assign col_ok[gi] = (int'(cen_col_reg) + OFS >= 0) && (int'(cen_col_reg) + OFS < IMG_W);
  end

  for (genvar gi = 0; gi < WIN * WIN; gi++) begin : g_tap
    assign masked_taps[gi] = taps[gi] & row_ok[gi / WIN] & col_ok[gi % WIN];
  end

  assign win_cnt  = CNT_W'(popcount(MAX_TAPS'(masked_taps), WIN));
  assign filt_pix = enable_q_reg ? (win_cnt >= threshold_q_reg) : taps[H*WIN + H];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      in_cnt_reg      <= '0;
      o_row_reg       <= '0;
      o_col_reg       <= '0;
      enable_q_reg    <= 1'b0;
      threshold_q_reg <= '0;
      gen_reg         <= 1'b0;
      cen_row_reg     <= '0;
      cen_col_reg     <= '0;
      out_valid_reg   <= 1'b0;
      out_sof_reg     <= 1'b0;
      out_eol_reg     <= 1'b0;
      out_pix_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      in_cnt_reg <= in_cnt_next;
      o_row_reg  <= o_row_next;
      o_col_reg  <= o_col_next;
      if (sof_acc) begin
        enable_q_reg    <= enable;
        threshold_q_reg <= threshold;
      end
      // Window settles on the shift edge; the result is registered on the next.
      gen_reg <= produce;
      if (produce) begin
        cen_row_reg <= o_row_reg;
        cen_col_reg <= o_col_reg;
      end
      out_valid_reg <= gen_reg;
      out_sof_reg   <= gen_reg && (cen_row_reg == '0) && (cen_col_reg == '0);
      out_eol_reg   <= gen_reg && (cen_col_reg == COL_W'(IMG_W - 1));
      out_pix_reg   <= gen_reg && filt_pix;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sof   = out_sof_reg;
  assign out_eol   = out_eol_reg;
  assign out_pix   = out_pix_reg;

endmodule

// File: tb/tb_box_filter_stream.sv
// Directed bench: an 8x4 3x3 instance (a_*) and an 8x6 5x5 instance (b_*).
module tb_box_filter_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_enable, a_in_valid, a_in_ready, a_in_sof, a_in_pix;
  logic [3:0] a_threshold;
  logic       a_out_valid, a_out_sof, a_out_eol, a_out_pix;
  logic       b_enable, b_in_valid, b_in_ready, b_in_sof, b_in_pix;
  logic [4:0] b_threshold;
  logic       b_out_valid, b_out_sof, b_out_eol, b_out_pix;

  int tests = 0;
  int fails = 0;

  box_filter_stream #(.IMG_W(8), .IMG_H(4), .WIN(3)) u_a (
    .clk(clk), .rst(rst), .enable(a_enable), .threshold(a_threshold),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sof(a_in_sof), .in_pix(a_in_pix),
    .out_valid(a_out_valid), .out_sof(a_out_sof), .out_eol(a_out_eol), .out_pix(a_out_pix)
  );

  box_filter_stream #(.IMG_W(8), .IMG_H(6), .WIN(5)) u_b (
    .clk(clk), .rst(rst), .enable(b_enable), .threshold(b_threshold),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sof(b_in_sof), .in_pix(b_in_pix),
    .out_valid(b_out_valid), .out_sof(b_out_sof), .out_eol(b_out_eol), .out_pix(b_out_pix)
  );

  // Output history for both instances.
  logic a_pix_h [1024];
  logic a_sof_h [1024];
  logic a_eol_h [1024];
  logic b_pix_h [1024];
  logic b_sof_h [1024];
  logic b_eol_h [1024];
  int a_n = 0;
  int b_n = 0;

  always @(negedge clk) begin
    if (a_out_valid) begin
      if (a_n < 1024) begin
        a_pix_h[a_n] <= a_out_pix;
        a_sof_h[a_n] <= a_out_sof;
        a_eol_h[a_n] <= a_out_eol;
      end
      a_n <= a_n + 1;
    end
    if (b_out_valid) begin
      if (b_n < 1024) begin
        b_pix_h[b_n] <= b_out_pix;
        b_sof_h[b_n] <= b_out_sof;
        b_eol_h[b_n] <= b_out_eol;
      end
      b_n <= b_n + 1;
    end
  end

  task automatic drive(input bit sel, input logic v, input logic s, input logic p,
                       input logic e, input logic [4:0] t);
    a_in_valid = !sel && v; a_in_sof = s; a_in_pix = p; a_enable = e; a_threshold = t[3:0];
    b_in_valid = sel && v;  b_in_sof = s; b_in_pix = p; b_enable = e; b_threshold = t;
  endtask

  // Sends npix pixels (sof on the first); enable/threshold are inverted after the
  // first pixel so that only the sof-time values may matter. wait_n < 0 returns
  // right after the last pixel, otherwise waits for the output count to reach wait_n.
  task automatic send_frame(input bit sel, input logic [63:0] img, input int npix,
                            input logic en, input logic [4:0] thr, input int gap,
                            input int wait_n, output int acc10_cyc,
                            output int first_out_cyc, output int rdy_low);
    int i, cyc, n_now;
    logic rdy;
    i = 0; cyc = 0; acc10_cyc = -1; first_out_cyc = -1; rdy_low = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        tests++; fails++;
        $display("FAIL frame_timeout sel=%0d outputs=%0d required=%0d", sel, sel ? b_n : a_n, wait_n);
        drive(sel, 1'b0, 1'b0, 1'b0, en, thr);
        return;
      end
      if ((sel ? b_out_valid : a_out_valid) && first_out_cyc < 0) first_out_cyc = cyc;
      rdy   = sel ? b_in_ready : a_in_ready;
      n_now = sel ? b_n : a_n;
      if (i < npix) begin
        if (gap > 0 && $urandom_range(0, gap) == 0) begin
          drive(sel, 1'b0, 1'b0, 1'($urandom_range(0, 1)), ~en, ~thr);
        end else begin
          drive(sel, 1'b1, (i == 0), img[i], (i == 0) ? en : ~en, (i == 0) ? thr : ~thr);
          if (rdy) begin
            if (i == 9) acc10_cyc = cyc;
            i++;
          end
        end
      end else begin
        drive(sel, 1'b0, 1'b0, 1'b0, en, thr);
        if (wait_n < 0) return;
        if (!rdy) rdy_low++;
        if (n_now >= wait_n && rdy) return;
      end
    end
  endtask

  task automatic collect(input bit sel, input int base, input int n,
                         output logic [63:0] p, output logic [63:0] s, output logic [63:0] e);
    p = '0; s = '0; e = '0;
    for (int i = 0; i < n; i++) begin
      p[i] = sel ? b_pix_h[base+i] : a_pix_h[base+i];
      s[i] = sel ? b_sof_h[base+i] : a_sof_h[base+i];
      e[i] = sel ? b_eol_h[base+i] : a_eol_h[base+i];
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    b_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if ({a_out_valid, a_out_sof, a_out_eol, a_out_pix, a_in_ready} !== 5'b00001) begin
        fails++;
        $display("FAIL reset_idle_a cycle=%0d got=%b required=00001", c,
                 {a_out_valid, a_out_sof, a_out_eol, a_out_pix, a_in_ready});
      end
      tests++;
      if ({b_out_valid, b_out_sof, b_out_eol, b_out_pix, b_in_ready} !== 5'b00001) begin
        fails++;
        $display("FAIL reset_idle_b cycle=%0d got=%b required=00001", c,
                 {b_out_valid, b_out_sof, b_out_eol, b_out_pix, b_in_ready});
      end
    end
    $display("[TB] reset/idle checked for 10 cycles");
  endtask

  task automatic test_all_ones;
    logic [63:0] p, s, e;
    int base, x, y, z;
    base = a_n;
    send_frame(1'b0, 64'hFFFF_FFFF, 32, 1'b1, 5'd9, 0, base + 32, x, y, z);
    collect(1'b0, base, 32, p, s, e);
    tests++;
    if (a_n - base !== 32) begin
      fails++; $display("FAIL all_ones_count got=%0d required=32", a_n - base);
    end
    tests++;
    if (p[31:0] !== 32'h007E_7E00) begin
      fails++; $display("FAIL all_ones_thr9 got=%h required=007e7e00", p[31:0]);
    end
    tests++;
    if (s[31:0] !== 32'h0000_0001 || e[31:0] !== 32'h8080_8080) begin
      fails++; $display("FAIL all_ones_flags sof=%h eol=%h required sof=00000001 eol=80808080", s[31:0], e[31:0]);
    end
    $display("[TB] all-ones thr=9 frame: pix=%h", p[31:0]);
    base = a_n;
    send_frame(1'b0, 64'hFFFF_FFFF, 32, 1'b1, 5'd4, 0, base + 32, x, y, z);
    collect(1'b0, base, 32, p, s, e);
    tests++;
    if (p[31:0] !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL all_ones_thr4 got=%h required=ffffffff", p[31:0]);
    end
    $display("[TB] all-ones thr=4 frame: pix=%h", p[31:0]);
  endtask

  task automatic test_single_one;
    logic [63:0] p, s, e;
    int base, x, y, z;
    base = a_n;
    send_frame(1'b0, 64'h0000_0200, 32, 1'b1, 5'd2, 0, base + 32, x, y, z);
    collect(1'b0, base, 32, p, s, e);
    tests++;
    if (p[31:0] !== 32'h0000_0000) begin
      fails++; $display("FAIL single_thr2 got=%h required=00000000", p[31:0]);
    end
    $display("[TB] single-one thr=2 frame: pix=%h", p[31:0]);
    base = a_n;
    send_frame(1'b0, 64'h0000_0200, 32, 1'b1, 5'd1, 0, base + 32, x, y, z);
    collect(1'b0, base, 32, p, s, e);
    tests++;
    if (p[31:0] !== 32'h0007_0707) begin
      fails++; $display("FAIL single_thr1 got=%h required=00070707", p[31:0]);
    end
    tests++;
    if (s[31:0] !== 32'h0000_0001) begin
      fails++; $display("FAIL single_sof got=%h required=00000001", s[31:0]);
    end
    tests++;
    if (e[31:0] !== 32'h8080_8080) begin
      fails++; $display("FAIL single_eol got=%h required=80808080", e[31:0]);
    end
    $display("[TB] single-one thr=1 frame: pix=%h", p[31:0]);
  endtask

  task automatic test_bypass;
    logic [63:0] p, s, e, img;
    int base, acc10, first_out, rdy_low;
    img = {32'h0, 32'($urandom())};
    base = a_n;
    send_frame(1'b0, img, 32, 1'b0, 5'd1, 2, base + 32, acc10, first_out, rdy_low);
    collect(1'b0, base, 32, p, s, e);
    tests++;
    if (p[31:0] !== img[31:0]) begin
      fails++; $display("FAIL bypass_data got=%h required=%h", p[31:0], img[31:0]);
    end
    // Accept edge falls after negedge acc10; the output edge is one clock later.
    tests++;
    if (first_out !== acc10 + 2) begin
      fails++; $display("FAIL bypass_latency first_out=%0d required=%0d", first_out, acc10 + 2);
    end
    tests++;
    if (rdy_low !== 9) begin
      fails++; $display("FAIL bypass_flush_ready_low got=%0d required=9", rdy_low);
    end
    $display("[TB] bypass frame: in=%h out=%h flush=%0d", img[31:0], p[31:0], rdy_low);
  endtask

  task automatic test_abort;
    logic [63:0] p, s, e;
    int base, x, y, z;
    base = a_n;
    send_frame(1'b0, 64'h0000_0000_5AC3_0F96, 20, 1'b1, 5'd3, 0, -1, x, y, z);
    send_frame(1'b0, 64'hFFFF_FFFF, 32, 1'b1, 5'd9, 0, base + 43, x, y, z);
    repeat (5) @(negedge clk);
    collect(1'b0, base, 43, p, s, e);
    tests++;
    if (a_n - base !== 43) begin
      fails++; $display("FAIL abort_count got=%0d required=43", a_n - base);
    end
    tests++;
    if (s[42:0] !== 43'h801) begin
      fails++; $display("FAIL abort_sof got=%h required=801", s[42:0]);
    end
    tests++;
    if (p[42:11] !== 32'h007E_7E00) begin
      fails++; $display("FAIL abort_new_frame got=%h required=007e7e00", p[42:11]);
    end
    tests++;
    if (e[42:11] !== 32'h8080_8080) begin
      fails++; $display("FAIL abort_eol got=%h required=80808080", e[42:11]);
    end
    $display("[TB] abort frame: outputs=%0d new=%h", a_n - base, p[42:11]);
  endtask

  task automatic test_reset_mid;
    logic [63:0] p, s, e;
    int base, x, y, z;
    send_frame(1'b0, 64'hFFFF_FFFF, 15, 1'b1, 5'd9, 0, -1, x, y, z);
    rst = 1'b1;
    @(negedge clk);
    base = a_n;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if (a_n !== base || a_in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_mid_quiet outputs=%0d ready=%b required 0 and 1", a_n - base, a_in_ready);
    end
    base = a_n;
    send_frame(1'b0, 64'hFFFF_FFFF, 32, 1'b1, 5'd9, 0, base + 32, x, y, z);
    collect(1'b0, base, 32, p, s, e);
    tests++;
    if (p[31:0] !== 32'h007E_7E00 || s[31:0] !== 32'h1) begin
      fails++; $display("FAIL reset_mid_next got=%h sof=%h required=007e7e00 sof=1", p[31:0], s[31:0]);
    end
    $display("[TB] reset mid-frame then frame: pix=%h", p[31:0]);
  endtask

  task automatic test_win5;
    logic [63:0] p, s, e;
    int base, x, y, z;
    base = b_n;
    send_frame(1'b1, 64'h0000_FFFF_FFFF_FFFF, 48, 1'b1, 5'd25, 0, base + 48, x, y, z);
    collect(1'b1, base, 48, p, s, e);
    tests++;
    if (p[47:0] !== 48'h0000_3C3C_0000) begin
      fails++; $display("FAIL win5_thr25 got=%h required=00003c3c0000", p[47:0]);
    end
    tests++;
    if (s[47:0] !== 48'h1 || e[47:0] !== 48'h8080_8080_8080) begin
      fails++; $display("FAIL win5_flags sof=%h eol=%h required sof=1 eol=808080808080", s[47:0], e[47:0]);
    end
    $display("[TB] win5 thr=25 frame: pix=%h", p[47:0]);
    base = b_n;
    send_frame(1'b1, 64'h0000_FFFF_FFFF_FFFF, 48, 1'b1, 5'd9, 0, base + 48, x, y, z);
    collect(1'b1, base, 48, p, s, e);
    tests++;
    if (p[0] !== 1'b1) begin
      fails++; $display("FAIL win5_corner got=%b required=1", p[0]);
    end
    tests++;
    if (p[47:0] !== 48'hFFFF_FFFF_FFFF) begin
      fails++; $display("FAIL win5_thr9 got=%h required=ffffffffffff", p[47:0]);
    end
    $display("[TB] win5 thr=9 frame: pix=%h", p[47:0]);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_single_one();
    test_bypass();
    test_abort();
    test_reset_mid();
    test_win5();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/box_filter_stream.md
Name: box_filter_stream

Overview:
Streaming, parametrised successor to the fixed 3x3 box filter. It accepts a raster-order 1-bit motion map, builds the WIN x WIN neighbourhood internally from line buffers, and applies zero padding at the image borders. Each pixel is thresholded on its neighbourhood popcount. It sits between the motion-detection stage and the motion-map output/statistics stage, with a per-frame programmable threshold and a bypass mode.

Parameters:
IMG_W, 640, pixels per line (>= WIN)
IMG_H, 480, lines per frame (>= WIN)
WIN, 3, window side; odd, 3..7; H = WIN/2
CNT_W, $clog2(WIN*WIN+1), popcount/threshold width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  1 = filter, 0 = bypass (out_pix = centre pixel); sampled with in_sof
threshold  in  CNT_W  min ones in window for out_pix=1; sampled with in_sof
in_valid  in  1  input pixel valid
in_ready  out  1  block accepts pixel (in_valid & in_ready = accept)
in_sof  in  1  marks pixel (0,0) of a frame
in_pix  in  1  motion bit
out_valid  out  1  output pixel valid (no backpressure)
out_sof  out  1  with output pixel (0,0)
out_eol  out  1  with output pixel at column IMG_W-1
out_pix  out  1  filtered motion bit

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. Reset clears the FSM to IDLE, all counters, line buffers and window to 0. After reset: out_valid=0, out_sof=0, out_eol=0, out_pix=0, in_ready=1.
- Pipeline delay D = H*IMG_W + H accepted pixels. Output pixel (r,c) is registered one cycle after input pixel number r*IMG_W+c+D is accepted, or one cycle after the corresponding FLUSH slot.
- Window: count = number of 1s among taps (r+dr, c+dc), |dr|,|dc| <= H, centre included. Taps outside the image read 0; masking is driven by output-side row/col counters. Line-buffer contents from the previous row or frame must never leak.
- out_pix = enable_q ? (count >= threshold_q) : centre tap. With threshold_q=0 every output is 1 when enable_q=1. Compare is unsigned at CNT_W bits.
- FSM states:
  - IDLE: in_ready=1. Accepted pixels without in_sof are dropped. An accepted pixel with in_sof latches enable_q/threshold_q, becomes (0,0), and moves the FSM to FILL.
  - FILL: accept D pixels in total, no outputs; then go to RUN.
  - RUN: each accepted pixel yields one output next cycle. After input pixel (IMG_H-1, IMG_W-1) is accepted, go to FLUSH.
  - FLUSH: in_ready=0. Inject D zero pixels, one per cycle, each producing one output. Then go to IDLE.
- Exactly IMG_W*IMG_H outputs per completed frame. out_sof is on the first output and out_eol every IMG_W outputs.
- in_valid gaps in FILL or RUN stall the pipeline with no output; state is held.
- in_sof accepted in FILL or RUN aborts the frame: pending outputs are discarded, no out_sof/out_eol is emitted for the old frame, line buffers are treated as zero, and the pixel is (0,0) of the new frame (state FILL). in_sof is not accepted during FLUSH (in_ready=0).
- enable/threshold changes mid-frame have no effect until the next in_sof.
- rst mid-frame: immediate return to reset state; no further outputs from the old frame.

Decomposition:
- box_filter_pkg: state enum (IDLE, FILL, RUN, FLUSH), popcount function parametrised on WIN, and localparams H and D expressed from the parameters.
- Sub-module box_filter_linebuf: WIN-1 line buffers of IMG_W bits plus the WIN x WIN window shift register. Shift-enable input, flat WIN*WIN output. The top level holds the FSM, counters, border masking and compare.

Test Plan:
- Reset, then idle for 10 cycles -> out_valid=0 throughout, in_ready=1, out_pix=0.
- IMG_W=8, IMG_H=4, WIN=3, all-ones frame, threshold=9, enable=1 -> 32 outputs; rows 1-2 cols 1-6 = 1, all border pixels 0 (corners count 4, edges 6). Same frame with threshold=4 -> all 32 outputs = 1.
- Single 1 at (1,1), rest 0. threshold=2 -> 32 zeros. threshold=1 -> exactly rows 0-2 cols 0-2 = 1, rest 0. out_sof on output #0, out_eol on outputs #7/15/23/31.
- enable=0 with a random frame and random in_valid gaps -> out_pix stream equals the input stream; first output one cycle after the 10th accepted pixel; in_ready=0 for exactly 9 cycles after the last pixel.
- in_sof injected at pixel 20 of a frame -> no further old-frame outputs; the new frame yields 32 correct outputs starting with out_sof.
- WIN=5, IMG_W=8, IMG_H=6, all-ones frame, threshold=25 -> only (2..3, 2..5) = 1; corner count 9 with threshold 9 -> corner = 1.
